mc_ctrl: RTL and testbench
==========================

// Module: mc_ctrl
// PURPOSE
// Multi-cycle MIPS controller FSM. Sequences fetch/decode/execute/memory/writeback over the shared datapath (PC, IR, GRF, ALU, DM).
// Decodes Op/Funct from IR. Drives all write enables, including the GRF write enable, and all datapath mux selects.
// Supports addu, subu, jr, ori, lw, sw, beq, lui, j, jal.
// PARAMETERS
// RA_SEL   2'd2   RegDst code that selects $31 (link register for jal)
// PORTS
// Clk       in   1  clock, all state updates on posedge
// Reset     in   1  synchronous, active-high; clock Clk
// Op        in   6  IR[31:26]
// Funct     in   6  IR[5:0]
// Zero      in   1  ALU equal flag, valid in EXE
// PCWr      out  1  PC register write enable
// IRWr      out  1  IR write enable
// RFWr      out  1  GRF write enable (WE)
// MemWr     out  1  data-memory write enable
// NPCSel    out  2  0=PC+4, 1=branch, 2=jump imm26, 3=jr (GPR[rs])
// RegDst    out  2  0=rt, 1=rd, 2=$31
// WDSel     out  2  0=ALU result, 1=DM read data, 2=PC+4
// ALUBSel   out  1  0=GPR[rt], 1=extended imm
// ExtOp     out  1  0=zero-extend, 1=sign-extend
// ALUOp     out  3  0=ADD, 1=SUB, 2=OR, 3=LUI (imm<<16)
// InstrDone out  1  one-cycle pulse in the final cycle of each instruction
// BEHAVIOUR
// - States: FETCH=0, DCD=1, EXE=2, MEM=3, WB=4. 3-bit state register. Reset moves state to FETCH on the posedge.
// - Outputs are combinational from state+Op+Funct. Op/Funct are stable from DCD to the end of the instruction.
// - While Reset=1: PCWr, IRWr, RFWr, MemWr and InstrDone are forced 0. Selects default to 0.
// - FETCH: IRWr=1, PCWr=1, NPCSel=0. Next state is DCD.
// - DCD (GRF read):
//   - j: PCWr=1, NPCSel=2. Next FETCH.
//   - jal: PCWr=1, NPCSel=2, RFWr=1, RegDst=RA_SEL, WDSel=2. Next FETCH.
//   - jr (Op=0, Funct=001000): PCWr=1, NPCSel=3. Next FETCH.
//   - Unsupported Op, or R-type with unsupported Funct: no writes, InstrDone=1. Next FETCH (executes as nop).
//   - All other supported instructions: next EXE.
//   - The j/jal/jr cases also assert InstrDone=1.
// - EXE:
//   - addu (100001): ALUOp=ADD, next WB.
//   - subu (100011): ALUOp=SUB, next WB.
//   - ori: ALUBSel=1, ExtOp=0, ALUOp=OR, next WB.
//   - lui: ALUBSel=1, ALUOp=LUI, next WB.
//   - lw/sw: ALUBSel=1, ExtOp=1, ALUOp=ADD, next MEM.
//   - beq: ALUOp=SUB, NPCSel=1, PCWr=Zero, InstrDone=1, next FETCH.
// - MEM:
//   - sw: MemWr=1, InstrDone=1, next FETCH.
//   - lw: DM read, next WB.
//   - EXE/MEM selects (ALUBSel, ExtOp, ALUOp) are held for the instruction.
// - WB: RFWr=1 and InstrDone=1. Next FETCH.
//   - R-type: RegDst=1, WDSel=0. ori/lui: RegDst=0, WDSel=0. lw: RegDst=0, WDSel=1.
// - Opcodes: R=000000, ori=001101, lui=001111, lw=100011, sw=101011, beq=000100, j=000010, jal=000011.
// - Latency (cycles):
//   - j/jal/jr/invalid: 2
//   - beq: 3
//   - sw, R-type, ori, lui: 4
//   - lw: 5
// - At most one of RFWr, MemWr is high in any cycle. PCWr is never high in MEM or WB.
// - Reset mid-instruction: the instruction is aborted and no write enable is asserted in the Reset cycle. Fetch restarts from FETCH.
// - Illegal state encodings (5-7) return to FETCH on the next edge with no writes.
// STRUCTURE
// - Shared package mc_defs: state codes, opcode/funct constants, NPCSel/RegDst/WDSel/ALUOp encodings.
// - One sub-module, mc_decode: combinational Op/Funct -> one-hot instruction class.
// - mc_ctrl holds the state register and per-state output logic.
// TESTING
// - Reset=1 for 2 cycles with Op=lw -> all write enables 0, state=FETCH. The first post-reset cycle has IRWr=PCWr=1.
// - lw (Op=100011) -> FETCH, DCD, EXE (ALUBSel=1, ExtOp=1), MEM, WB (RFWr=1, WDSel=1, RegDst=0). InstrDone only in WB, total 5 cycles.
// - beq with Zero=1 -> PCWr=1 and NPCSel=1 in EXE. With Zero=0 -> PCWr=0. Both take 3 cycles.
// - jal -> DCD has PCWr=1, RFWr=1, RegDst=2, WDSel=2, NPCSel=2, InstrDone=1. Then FETCH.
// - Op=0, Funct=100001 (addu) -> WB has RegDst=1, WDSel=0, RFWr=1. Op=111111 -> DCD InstrDone=1, no writes.
// - sw with Reset asserted in MEM -> MemWr=0 that cycle. Next state FETCH.

Source files
------------

// File: rtl/mc_defs.sv
// Shared definitions for the multi-cycle MIPS controller: state codes,
// opcode/funct constants, datapath select encodings and instruction class.
package mc_defs;

   localparam int unsigned ST_W  = 3;
   localparam int unsigned OP_W  = 6;
   localparam int unsigned SEL_W = 2;
   localparam int unsigned ALU_W = 3;

   // Controller states
   localparam logic [ST_W-1:0] S_FETCH = 3'd0;
   localparam logic [ST_W-1:0] S_DCD   = 3'd1;
   localparam logic [ST_W-1:0] S_EXE   = 3'd2;
   localparam logic [ST_W-1:0] S_MEM   = 3'd3;
   localparam logic [ST_W-1:0] S_WB    = 3'd4;

   // Opcodes (IR[31:26])
   localparam logic [OP_W-1:0] OP_R   = 6'b000000;
   localparam logic [OP_W-1:0] OP_ORI = 6'b001101;
   localparam logic [OP_W-1:0] OP_LUI = 6'b001111;
   localparam logic [OP_W-1:0] OP_LW  = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW  = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ = 6'b000100;
   localparam logic [OP_W-1:0] OP_J   = 6'b000010;
   localparam logic [OP_W-1:0] OP_JAL = 6'b000011;

   // Funct codes (IR[5:0]) for R-type
   localparam logic [OP_W-1:0] FN_ADDU = 6'b100001;
   localparam logic [OP_W-1:0] FN_SUBU = 6'b100011;
   localparam logic [OP_W-1:0] FN_JR   = 6'b001000;

   // Next-PC select
   localparam logic [SEL_W-1:0] NPC_PC4 = 2'd0;
   localparam logic [SEL_W-1:0] NPC_BR  = 2'd1;
   localparam logic [SEL_W-1:0] NPC_J   = 2'd2;
   localparam logic [SEL_W-1:0] NPC_JR  = 2'd3;

   // Register destination select
   localparam logic [SEL_W-1:0] RD_RT  = 2'd0;
   localparam logic [SEL_W-1:0] RD_RD  = 2'd1;
   localparam logic [SEL_W-1:0] RA_SEL = 2'd2;

   // GRF write-data select
   localparam logic [SEL_W-1:0] WD_ALU = 2'd0;
   localparam logic [SEL_W-1:0] WD_DM  = 2'd1;
   localparam logic [SEL_W-1:0] WD_PC4 = 2'd2;

   // ALU operations
   localparam logic [ALU_W-1:0] ALU_ADD = 3'd0;
   localparam logic [ALU_W-1:0] ALU_SUB = 3'd1;
   localparam logic [ALU_W-1:0] ALU_OR  = 3'd2;
   localparam logic [ALU_W-1:0] ALU_LUI = 3'd3;

   // One-hot instruction class; bad covers every unsupported encoding
   typedef struct packed {
      logic addu;
      logic subu;
      logic jr;
      logic ori;
      logic lui;
      logic lw;
      logic sw;
      logic beq;
      logic j;
      logic jal;
      logic bad;
   } instr_cls_t;

endpackage

// File: rtl/mc_decode.sv
// Op/Funct decoder: maps the current IR fields to a one-hot instruction class.
module mc_decode
   import mc_defs::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output instr_cls_t cls
);

   // Opcode first, then funct for R-type; anything unrecognised is bad
   always_comb begin
      cls = '0;
      case (op)
         OP_R: begin
            case (funct)
               FN_ADDU: cls.addu = 1'b1;
               FN_SUBU: cls.subu = 1'b1;
               FN_JR:   cls.jr   = 1'b1;
               default: cls.bad  = 1'b1;
            endcase
         end
         OP_ORI:  cls.ori = 1'b1;
         OP_LUI:  cls.lui = 1'b1;
         OP_LW:   cls.lw  = 1'b1;
         OP_SW:   cls.sw  = 1'b1;
         OP_BEQ:  cls.beq = 1'b1;
         OP_J:    cls.j   = 1'b1;
         OP_JAL:  cls.jal = 1'b1;
         default: cls.bad = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS controller: FETCH/DCD/EXE/MEM/WB sequencing with
// combinational write enables and datapath selects.
module mc_ctrl
   import mc_defs::*;
(
   input  logic       Clk,
   input  logic       Reset,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       Zero,
   output logic       PCWr,
   output logic       IRWr,
   output logic       RFWr,
   output logic       MemWr,
   output logic [1:0] NPCSel,
   output logic [1:0] RegDst,
   output logic [1:0] WDSel,
   output logic       ALUBSel,
   output logic       ExtOp,
   output logic [2:0] ALUOp,
   output logic       InstrDone
);

   logic [ST_W-1:0]  state;
   logic [ST_W-1:0]  state_nxt;
   instr_cls_t       cls;
   logic             alub_i;
   logic             ext_i;
   logic [ALU_W-1:0] aluop_i;

   mc_decode u_decode (
      .op    (Op),
      .funct (Funct),
      .cls   (cls)
   );

   // State register, synchronous reset to FETCH
   always_ff @(posedge Clk) begin
      if (Reset) state <= S_FETCH;
      else       state <= state_nxt;
   end

   // ALU operand/operation selects, held from EXE through the end of the instruction
   always_comb begin
      alub_i  = 1'b0;
      ext_i   = 1'b0;
      aluop_i = ALU_ADD;
      if (cls.subu || cls.beq) aluop_i = ALU_SUB;
      if (cls.ori) begin
         alub_i  = 1'b1;
         aluop_i = ALU_OR;
      end
      if (cls.lui) begin
         alub_i  = 1'b1;
         aluop_i = ALU_LUI;
      end
      if (cls.lw || cls.sw) begin
         alub_i = 1'b1;
         ext_i  = 1'b1;
      end
   end

   // Next state and per-state outputs; Reset suppresses every output
   always_comb begin
      state_nxt = S_FETCH;
      PCWr      = 1'b0;
      IRWr      = 1'b0;
      RFWr      = 1'b0;
      MemWr     = 1'b0;
      NPCSel    = NPC_PC4;
      RegDst    = RD_RT;
      WDSel     = WD_ALU;
      ALUBSel   = 1'b0;
      ExtOp     = 1'b0;
      ALUOp     = ALU_ADD;
      InstrDone = 1'b0;
      if (!Reset) begin
         case (state)
            S_FETCH: begin
               IRWr      = 1'b1;
               PCWr      = 1'b1;
               state_nxt = S_DCD;
            end
            S_DCD: begin
               if (cls.j || cls.jal) begin
                  PCWr      = 1'b1;
                  NPCSel    = NPC_J;
                  InstrDone = 1'b1;
               end
               if (cls.jal) begin
                  RFWr   = 1'b1;
                  RegDst = RA_SEL;
                  WDSel  = WD_PC4;
               end
               if (cls.jr) begin
                  PCWr      = 1'b1;
                  NPCSel    = NPC_JR;
                  InstrDone = 1'b1;
               end
               if (cls.bad) InstrDone = 1'b1;
               if (cls.addu || cls.subu || cls.ori || cls.lui ||
                   cls.lw || cls.sw || cls.beq)
                  state_nxt = S_EXE;
            end
            S_EXE: begin
               ALUBSel = alub_i;
               ExtOp   = ext_i;
               ALUOp   = aluop_i;
               if (cls.beq) begin
                  NPCSel    = NPC_BR;
                  PCWr      = Zero;
                  InstrDone = 1'b1;
               end else if (cls.lw || cls.sw) begin
                  state_nxt = S_MEM;
               end else if (cls.addu || cls.subu || cls.ori || cls.lui) begin
                  state_nxt = S_WB;
               end
            end
            S_MEM: begin
               ALUBSel = alub_i;
               ExtOp   = ext_i;
               ALUOp   = aluop_i;
               if (cls.sw) begin
                  MemWr     = 1'b1;
                  InstrDone = 1'b1;
               end else if (cls.lw) begin
                  state_nxt = S_WB;
               end
            end
            S_WB: begin
               ALUBSel   = alub_i;
               ExtOp     = ext_i;
               ALUOp     = aluop_i;
               RFWr      = 1'b1;
               InstrDone = 1'b1;
               RegDst    = (cls.addu || cls.subu) ? RD_RD : RD_RT;
               WDSel     = cls.lw ? WD_DM : WD_ALU;
            end
            default: state_nxt = S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction vector table of expected
// cycle-by-cycle outputs, fed through an expectation queue to a monitor.
module tb_mc_ctrl;

   typedef struct packed {
      logic       pcwr;
      logic       irwr;
      logic       rfwr;
      logic       memwr;
      logic [1:0] npcsel;
      logic [1:0] regdst;
      logic [1:0] wdsel;
      logic       alubsel;
      logic       extop;
      logic [2:0] aluop;
      logic       done;
   } out_t;

   typedef struct {
      string name;
      out_t  exp;
   } sb_t;

   typedef struct {
      string      name;
      logic [5:0] op;
      logic [5:0] funct;
      logic       zero;
      int         ncyc;
      out_t [4:0] exp;
   } vec_t;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [5:0] Op;
   logic [5:0] Funct;
   logic       Zero;
   logic       PCWr, IRWr, RFWr, MemWr, ALUBSel, ExtOp, InstrDone;
   logic [1:0] NPCSel, RegDst, WDSel;
   logic [2:0] ALUOp;

   int   checks = 0;
   int   passes = 0;
   sb_t  sbq[$];
   vec_t vecs[$];

   mc_ctrl dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Op        (Op),
      .Funct     (Funct),
      .Zero      (Zero),
      .PCWr      (PCWr),
      .IRWr      (IRWr),
      .RFWr      (RFWr),
      .MemWr     (MemWr),
      .NPCSel    (NPCSel),
      .RegDst    (RegDst),
      .WDSel     (WDSel),
      .ALUBSel   (ALUBSel),
      .ExtOp     (ExtOp),
      .ALUOp     (ALUOp),
      .InstrDone (InstrDone)
   );

   always #5 Clk = ~Clk;

   function automatic out_t mk(input logic pw, input logic iw, input logic rw,
                               input logic mw, input logic [1:0] npc,
                               input logic [1:0] rd, input logic [1:0] wd,
                               input logic ab, input logic ext,
                               input logic [2:0] alu, input logic dn);
      out_t o;
      o.pcwr = pw;  o.irwr = iw;  o.rfwr = rw;  o.memwr = mw;
      o.npcsel = npc; o.regdst = rd; o.wdsel = wd;
      o.alubsel = ab; o.extop = ext; o.aluop = alu; o.done = dn;
      return o;
   endfunction

   // Mid-cycle monitor: compare live outputs with the oldest pending expectation
   always @(negedge Clk) begin
      out_t act;
      sb_t  e;
      act = {PCWr, IRWr, RFWr, MemWr, NPCSel, RegDst, WDSel,
             ALUBSel, ExtOp, ALUOp, InstrDone};
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         checks++;
         if (act === e.exp) passes++;
         else $display("FAIL %s: got %h (pw iw rw mw npc rd wd ab ext alu dn) required %h",
                       e.name, act, e.exp);
      end
   end

   // Drive one cycle of stimulus and queue what the outputs must be in it
   task automatic cyc(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input out_t exp, input string name);
      sb_t e;
      @(posedge Clk);
      #1;
      Reset = rst; Op = op; Funct = fn; Zero = z;
      e.name = name;
      e.exp  = exp;
      sbq.push_back(e);
   endtask

   task automatic add_vec(input string name, input logic [5:0] op, input logic [5:0] fn,
                          input logic z, input int n, input out_t e1, input out_t e2,
                          input out_t e3, input out_t e4);
      vec_t v;
      v.name = name; v.op = op; v.funct = fn; v.zero = z; v.ncyc = n;
      v.exp[0] = mk(1,1,0,0,0,0,0,0,0,0,0);
      v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3; v.exp[4] = e4;
      vecs.push_back(v);
   endtask

   initial begin
      out_t z0, fe;
      z0 = '0;
      fe = mk(1,1,0,0,0,0,0,0,0,0,0);
      Reset = 1'b1; Op = 6'b100011; Funct = 6'b0; Zero = 1'b0;

      //       name        op         funct      Z  n  DCD / EXE / MEM|WB / WB
      add_vec("lw",    6'b100011, 6'b000000, 0, 5, z0,
              mk(0,0,0,0,0,0,0,1,1,0,0), mk(0,0,0,0,0,0,0,1,1,0,0),
              mk(0,0,1,0,0,0,1,1,1,0,1));
      add_vec("sw",    6'b101011, 6'b000000, 0, 4, z0,
              mk(0,0,0,0,0,0,0,1,1,0,0), mk(0,0,0,1,0,0,0,1,1,0,1), z0);
      add_vec("addu",  6'b000000, 6'b100001, 0, 4, z0,
              z0, mk(0,0,1,0,0,1,0,0,0,0,1), z0);
      add_vec("subu",  6'b000000, 6'b100011, 1, 4, z0,
              mk(0,0,0,0,0,0,0,0,0,1,0), mk(0,0,1,0,0,1,0,0,0,1,1), z0);
      add_vec("ori",   6'b001101, 6'b100001, 0, 4, z0,
              mk(0,0,0,0,0,0,0,1,0,2,0), mk(0,0,1,0,0,0,0,1,0,2,1), z0);
      add_vec("lui",   6'b001111, 6'b000000, 0, 4, z0,
              mk(0,0,0,0,0,0,0,1,0,3,0), mk(0,0,1,0,0,0,0,1,0,3,1), z0);
      add_vec("beq_z1", 6'b000100, 6'b000000, 1, 3, z0,
              mk(1,0,0,0,1,0,0,0,0,1,1), z0, z0);
      add_vec("beq_z0", 6'b000100, 6'b000000, 0, 3, z0,
              mk(0,0,0,0,1,0,0,0,0,1,1), z0, z0);
      add_vec("j",     6'b000010, 6'b000000, 0, 2,
              mk(1,0,0,0,2,0,0,0,0,0,1), z0, z0, z0);
      add_vec("jal",   6'b000011, 6'b000000, 0, 2,
              mk(1,0,1,0,2,2,2,0,0,0,1), z0, z0, z0);
      add_vec("jr",    6'b000000, 6'b001000, 0, 2,
              mk(1,0,0,0,3,0,0,0,0,0,1), z0, z0, z0);
      add_vec("bad_op", 6'b111111, 6'b000000, 0, 2,
              mk(0,0,0,0,0,0,0,0,0,0,1), z0, z0, z0);
      add_vec("bad_fn", 6'b000000, 6'b000000, 0, 2,
              mk(0,0,0,0,0,0,0,0,0,0,1), z0, z0, z0);

      // Two reset cycles with lw on the bus: every output held low
      cyc(1, 6'b100011, 6'b0, 0, z0, "reset0");
      cyc(1, 6'b100011, 6'b0, 0, z0, "reset1");

      // Each instruction cycle-by-cycle; the next FETCH checks the latency
      foreach (vecs[i]) begin
         for (int c = 0; c < vecs[i].ncyc; c++)
            cyc(0, vecs[i].op, vecs[i].funct, vecs[i].zero, vecs[i].exp[c],
                $sformatf("%s_c%0d", vecs[i].name, c));
      end

      // sw aborted by Reset in MEM: no store, restart at FETCH
      cyc(0, 6'b101011, 6'b0, 0, fe, "swrst_fetch");
      cyc(0, 6'b101011, 6'b0, 0, z0, "swrst_dcd");
      cyc(0, 6'b101011, 6'b0, 0, mk(0,0,0,0,0,0,0,1,1,0,0), "swrst_exe");
      cyc(1, 6'b101011, 6'b0, 0, z0, "swrst_mem");
      cyc(0, 6'b101011, 6'b0, 0, fe, "swrst_refetch");

      // addu aborted by Reset in WB: no GRF write, restart at FETCH
      cyc(0, 6'b000000, 6'b100001, 0, z0, "addurst_dcd");
      cyc(0, 6'b000000, 6'b100001, 0, z0, "addurst_exe");
      cyc(1, 6'b000000, 6'b100001, 0, z0, "addurst_wb");
      cyc(0, 6'b000000, 6'b100001, 0, fe, "addurst_refetch");

      // jal right after a fetch, then back to FETCH
      cyc(0, 6'b000011, 6'b0, 0, mk(1,0,1,0,2,2,2,0,0,0,1), "jal2_dcd");
      cyc(0, 6'b000011, 6'b0, 0, fe, "jal2_fetch");

      @(negedge Clk);
      #1;
      if (sbq.size() != 0) begin
         checks++;
         $display("FAIL drain: %0d expectations left, required 0", sbq.size());
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
